// File: rtl/dibit_pkg.sv
// Shared types and helpers for the word-to-dibit feeder.
// PARITY_DIBIT_EN appends an even-parity dibit to every word.
package dibit_pkg;

    localparam int DIBIT_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Show-ahead word FIFO; extra pointer MSB separates full from empty.
module word_fifo
    import dibit_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/word_to_dibit.sv
// Buffers words and feeds them LSB-dibit-first to a 2-bit PISO.
// PARITY_DIBIT_EN adds a trailing {0, ^word} dibit per word.
module word_to_dibit
    import dibit_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  in_word,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DIBIT_W-1:0] dibit,
    output logic               valid_data,
    input  logic               piso_done,
    output logic               word_done,
    output logic               busy
);

    localparam int NDIB = DATA_W / DIBIT_W;
`ifdef PARITY_DIBIT_EN
    localparam int NSYM = NDIB + 1;
`else
    localparam int NSYM = NDIB;
`endif
    localparam int CW = (NSYM > 1) ? clog2(NSYM) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(NSYM - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t            state;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] sreg_sh;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              advance;
`ifdef PARITY_DIBIT_EN
    logic              par_q;
`endif

    assign in_ready = !fifo_full;
    assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
    assign sreg_sh  = sreg >> DIBIT_W;
    // done while the start pulse is still out belongs to no transfer of ours
    assign advance  = piso_done && !valid_data;

    word_fifo #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (in_valid && in_ready),
        .wdata(in_word),
        .pop  (fifo_pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            cnt        <= '0;
            dibit      <= '0;
            valid_data <= 1'b0;
            word_done  <= 1'b0;
            busy       <= 1'b0;
`ifdef PARITY_DIBIT_EN
            par_q      <= 1'b0;
`endif
        end else begin
            valid_data <= 1'b0;
            word_done  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        sreg       <= fifo_rdata;
                        cnt        <= CNT_LOAD;
                        dibit      <= fifo_rdata[DIBIT_W-1:0];
                        valid_data <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_WAIT;
`ifdef PARITY_DIBIT_EN
                        par_q      <= ^fifo_rdata;
`endif
                    end
                end
                ST_WAIT: begin
                    if (advance) begin
                        if (cnt != '0) begin
                            sreg       <= sreg_sh;
                            cnt        <= cnt - CNT_ONE;
                            valid_data <= 1'b1;
`ifdef PARITY_DIBIT_EN
                            dibit <= (cnt == CNT_ONE) ?
                                     {1'b0, par_q} :
                                     sreg_sh[DIBIT_W-1:0];
`else
                            dibit <= sreg_sh[DIBIT_W-1:0];
`endif
                        end else begin
                            word_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_word_to_dibit.sv
// Directed bench for word_to_dibit with a 2-cycle PISO model.
module tb_word_to_dibit;

`ifdef PARITY_DIBIT_EN
    localparam int NEXP = 5;
`else
    localparam int NEXP = 4;
`endif

    typedef struct {
        logic [7:0]      w;
        logic [3:0][1:0] d;
        logic            par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_word;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] dibit;
    logic       valid_data;
    logic       piso_done;
    logic       word_done;
    logic       busy;

    logic       pm;
    logic       inj;
    logic       pen;
    logic       pend;
    int         age;
    logic [1:0] last_d;
    logic [1:0] got[$];
    int         wd_cnt;
    int         ncmp;
    int         nerr;

    assign piso_done = pm | inj;

    always #5 clk = ~clk;

    word_to_dibit #(
        .DATA_W    (8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_word   (in_word),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dibit     (dibit),
        .valid_data(valid_data),
        .piso_done (piso_done),
        .word_done (word_done),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // PISO model: done pulses 2 cycles after valid_data, if enabled
    always @(posedge clk) begin
        #1;
        if (rst) begin
            pm   = 1'b0;
            pend = 1'b0;
        end else begin
            pm = 1'b0;
            if (pend) begin
                age++;
                if (age >= 2 && pen) begin
                    pm   = 1'b1;
                    pend = 1'b0;
                    chk("hold", dibit, last_d);
                end
            end
            if (valid_data) begin
                pend   = 1'b1;
                age    = 0;
                last_d = dibit;
                got.push_back(dibit);
            end
            if (word_done) wd_cnt++;
        end
    end

    task automatic push(input logic [7:0] w);
        bit ok;
        ok = 1'b0;
        in_word  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) ok = 1'b1;
            @(negedge clk);
            if (ok) break;
        end
        in_valid = 1'b0;
        ncmp++;
        if (!ok) begin
            nerr++;
            $display("FAIL push_timeout: word %0h not accepted", w);
        end
    endtask

    task automatic wait_wd();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (word_done) break;
        end
        chk("word_done_seen", word_done, 1);
    endtask

    task automatic check_got(input vec_t v);
        chk("ndibits", got.size(), NEXP);
        for (int j = 0; j < 4; j++) chk("dibit", got[j], v.d[j]);
`ifdef PARITY_DIBIT_EN
        chk("parity_dibit", got[4], {1'b0, v.par});
`endif
    endtask

    vec_t tbl[6];
    logic [7:0] ws[6];

    initial begin
        int k;
        int wd0;
        bit acc;
        logic [1:0] e;

        tbl[0] = '{w: 8'hB4, d: {2'b10, 2'b11, 2'b01, 2'b00}, par: 1'b0};
        tbl[1] = '{w: 8'h01, d: {2'b00, 2'b00, 2'b00, 2'b01}, par: 1'b1};
        tbl[2] = '{w: 8'h1E, d: {2'b00, 2'b01, 2'b11, 2'b10}, par: 1'b0};
        tbl[3] = '{w: 8'hA5, d: {2'b10, 2'b10, 2'b01, 2'b01}, par: 1'b0};
        tbl[4] = '{w: 8'h80, d: {2'b10, 2'b00, 2'b00, 2'b00}, par: 1'b1};
        tbl[5] = '{w: 8'h37, d: {2'b00, 2'b11, 2'b01, 2'b11}, par: 1'b1};
        ws = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        ncmp = 0; nerr = 0; wd_cnt = 0;
        rst = 1'b1; in_valid = 1'b0; in_word = '0;
        inj = 1'b0; pen = 1'b1; pm = 1'b0; pend = 1'b0; age = 0;
        last_d = '0;
        repeat (2) @(negedge clk);
        chk("rst_dibit", dibit, 0);
        chk("rst_valid", valid_data, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", in_ready, 1);
        chk("rel_wd", word_done, 0);

        // table of single words, latency checked on the first
        for (int i = 0; i < 6; i++) begin
            got.delete();
            push(tbl[i].w);
            if (i == 0) begin
                chk("lat_pre", valid_data, 0);
                @(negedge clk);
                chk("lat_vd", valid_data, 1);
                chk("lat_busy", busy, 1);
                chk("lat_dibit", dibit, 2'b00);
            end
            wait_wd();
            check_got(tbl[i]);
            @(negedge clk);
            chk("wd_pulse", word_done, 0);
            chk("busy_after", busy, 0);
        end

        // fill with PISO withheld, then release
        got.delete();
        wd0 = wd_cnt;
        pen = 1'b0;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            in_word  = (k < 6) ? ws[k] : 8'h00;
            in_valid = (k < 6);
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) k++;
        end
        chk("fill_count", k, 5);
        chk("full_ready", in_ready, 0);
        pen = 1'b1;
        for (int c = 0; c < 200 && k < 6; c++) begin
            in_word  = ws[k];
            in_valid = 1'b1;
            acc = in_ready;
            @(negedge clk);
            if (acc) k++;
        end
        in_valid = 1'b0;
        chk("sixth_acc", k, 6);
        chk("one_wd_first", wd_cnt - wd0, 1);
        for (int c = 0; c < 600 && wd_cnt - wd0 < 6; c++) @(negedge clk);
        chk("drain_wd", wd_cnt - wd0, 6);
        chk("drain_n", got.size(), 6 * NEXP);
        for (int n = 0; n < 6; n++) begin
            for (int j = 0; j < NEXP; j++) begin
                e = (j < 4) ? 2'((ws[n] >> (2 * j)) & 8'h3) :
                              {1'b0, ^ws[n]};
                chk("order", got[n * NEXP + j], e);
            end
        end
        @(negedge clk);

        // back-to-back words: single IDLE cycle
        got.delete();
        push(8'hFF);
        push(8'h00);
        wait_wd();
        chk("b2b_idle", busy, 0);
        @(negedge clk);
        chk("b2b_pop", valid_data, 1);
        chk("b2b_d0", dibit, 2'b00);
        wait_wd();
        chk("b2b_n", got.size(), 2 * NEXP);
        for (int j = 0; j < 4; j++) begin
            chk("b2b_ff", got[j], 2'b11);
            chk("b2b_00", got[NEXP + j], 2'b00);
        end
        @(negedge clk);

        // reset mid-word
        got.delete();
        push(8'hB4);
        for (int c = 0; c < 100 && got.size() < 3; c++) @(negedge clk);
        chk("mid_dibit3", dibit, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_dibit", dibit, 0);
        chk("mr_valid", valid_data, 0);
        chk("mr_busy", busy, 0);
        chk("mr_wd", word_done, 0);
        chk("mr_ready", in_ready, 1);
        @(negedge clk);
        got.delete();
        push(tbl[2].w);
        wait_wd();
        check_got(tbl[2]);
        @(negedge clk);

        // stray done pulses
        wd0 = wd_cnt;
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        chk("stray_idle_busy", busy, 0);
        chk("stray_idle_vd", valid_data, 0);
        chk("stray_idle_wd", word_done, 0);
        got.delete();
        pen = 1'b0;
        push(tbl[5].w);
        @(negedge clk);
        chk("stray_vd", valid_data, 1);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        chk("stray_hold", dibit, 2'b11);
        chk("stray_novd", valid_data, 0);
        chk("stray_n", got.size(), 1);
        chk("stray_busy", busy, 1);
        chk("stray_nowd", wd_cnt - wd0, 0);
        pen = 1'b1;
        wait_wd();
        check_got(tbl[5]);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
